// File: rtl/fetch_mem_unit.sv
// Multi-cycle fetch/memory unit: PC, IR, MDR and a wait-state memory FSM.
// Optional FMU_ADDR_CHECK_EN adds mem_err and out-of-range suppression; default wraps the address.
module fetch_mem_unit #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       DEPTH       = 1024,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] RESET_PC    = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              input_PC_PCWrite,
  input  logic [DATA_W-1:0] input_PC_newPC,
  output logic [DATA_W-1:0] output_PC,
  input  logic              input_mem_req,
  input  logic              IorD,
  input  logic              input_mem_write,
  input  logic [DATA_W-1:0] input_mem_data,
  input  logic              input_IR_write,
  input  logic [DATA_W-1:0] input_from_ALUOut,
  output logic [DATA_W-1:0] output_MDR,
  output logic [6:0]        Output_IR_Control,
  output logic [3:0]        Output_IR_RegA,
  output logic [3:0]        Output_IR_RegB,
  output logic [3:0]        Output_IR_RegD,
  output logic [DATA_W-1:0] Output_IR_Imm,
  output logic              mem_busy,
  output logic              mem_done
`ifdef FMU_ADDR_CHECK_EN
  ,
  output logic              mem_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     addr_q;
  logic              wr_q;
  logic              irw_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] req_addr_c;
  logic              req_oob_c;
  logic              op_fire_c;
  logic [DATA_W-1:0] rd_data_c;

  assign req_addr_c = IorD ? input_from_ALUOut : pc_q;

`ifdef FMU_ADDR_CHECK_EN
  assign req_oob_c = 32'(req_addr_c) >= 32'(DEPTH);
`else
  // Upper address bits are dropped on purpose: accesses wrap modulo DEPTH.
  logic unused_addr_hi_c;
  assign unused_addr_hi_c = ^(req_addr_c >> AW);
  assign req_oob_c        = 1'b0;
`endif

  assign op_fire_c = (state == WAIT) && (cnt == '0);
  assign rd_data_c = err_q ? '0 : mem[addr_q];

  // Storage array has no reset so its contents survive RST_N.
  always_ff @(posedge CLK) begin
    if (RST_N && op_fire_c && wr_q && !err_q) begin
      mem[addr_q] <= data_q;
    end
  end

  // PC, access FSM, MDR/IR and status pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      irw_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      mem_busy <= 1'b0;
      mem_done <= 1'b0;
`ifdef FMU_ADDR_CHECK_EN
      mem_err  <= 1'b0;
`endif
    end else begin
      mem_done <= 1'b0;
`ifdef FMU_ADDR_CHECK_EN
      mem_err  <= 1'b0;
`endif
      if (input_PC_PCWrite) begin
        pc_q <= input_PC_newPC;
      end
      case (state)
        IDLE: begin
          if (input_mem_req) begin
            addr_q   <= AW'(req_addr_c);
            err_q    <= req_oob_c;
            wr_q     <= input_mem_write;
            irw_q    <= input_IR_write;
            data_q   <= input_mem_data;
            cnt      <= CW'(WAIT_CYCLES);
            state    <= WAIT;
            mem_busy <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            if (!wr_q) begin
              mdr_q <= rd_data_c;
              if (irw_q) begin
                ir_q <= rd_data_c;
              end
            end
            mem_done <= 1'b1;
`ifdef FMU_ADDR_CHECK_EN
            mem_err  <= err_q;
`endif
            state    <= DONE;
          end
        end
        DONE: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

  assign output_PC         = pc_q;
  assign output_MDR        = mdr_q;
  assign Output_IR_Control = ir_q[6:0];
  assign Output_IR_RegA    = ir_q[10:7];
  assign Output_IR_RegB    = ir_q[14:11];
  assign Output_IR_RegD    = ir_q[10:7];
  assign Output_IR_Imm     = {{7{ir_q[DATA_W-1]}}, ir_q[DATA_W-1:7]};

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Randomized self-checking bench for fetch_mem_unit against an array/queue reference model.
module tb_fetch_mem_unit;
  localparam int          DW    = 16;
  localparam int          DEPTH = 1024;
  localparam int          WC    = 1;
  localparam logic [15:0] RPC   = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_write = 1'b0;
  logic [DW-1:0] new_pc = '0;
  logic [DW-1:0] out_pc;
  logic          mem_req = 1'b0;
  logic          iord = 1'b0;
  logic          mem_write = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          ir_write = 1'b0;
  logic [DW-1:0] from_alu = '0;
  logic [DW-1:0] mdr;
  logic [6:0]    ir_ctrl;
  logic [3:0]    ir_rega, ir_regb, ir_regd;
  logic [DW-1:0] ir_imm;
  logic          mem_busy, mem_done;
`ifdef FMU_ADDR_CHECK_EN
  logic          mem_err;
  logic          last_err;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_pc = RPC;
  logic [DW-1:0] m_mdr = '0;
  logic [DW-1:0] m_ir = '0;
  int            written_q[$];

  // Observations filled by the access driver
  int   lat;
  logic busy_seen;
  logic done_after;

  fetch_mem_unit #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WC), .RESET_PC(RPC)) dut (
    .CLK(clk), .RST_N(rst_n),
    .input_PC_PCWrite(pc_write), .input_PC_newPC(new_pc), .output_PC(out_pc),
    .input_mem_req(mem_req), .IorD(iord), .input_mem_write(mem_write),
    .input_mem_data(mem_data), .input_IR_write(ir_write), .input_from_ALUOut(from_alu),
    .output_MDR(mdr), .Output_IR_Control(ir_ctrl), .Output_IR_RegA(ir_rega),
    .Output_IR_RegB(ir_regb), .Output_IR_RegD(ir_regd), .Output_IR_Imm(ir_imm),
    .mem_busy(mem_busy), .mem_done(mem_done)
`ifdef FMU_ADDR_CHECK_EN
    , .mem_err(mem_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_op(input logic wr, input logic ad_sel, input logic irw,
                                   input logic [DW-1:0] alu, input logic [DW-1:0] wdata);
    logic [DW-1:0] a;
    int idx;
    a = ad_sel ? alu : m_pc;
`ifdef FMU_ADDR_CHECK_EN
    if (int'(a) >= DEPTH) begin
      if (!wr) begin
        m_mdr = '0;
        if (irw) m_ir = '0;
      end
      return;
    end
`endif
    idx = int'(a) % DEPTH;
    if (wr) m_mem[idx] = wdata;
    else begin
      m_mdr = m_mem[idx];
      if (irw) m_ir = m_mdr;
    end
  endfunction

  // Issue one request at the next edge and wait (bounded) for mem_done.
  task automatic access(input logic wr, input logic ad_sel, input logic irw,
                        input logic [DW-1:0] alu, input logic [DW-1:0] wdata,
                        input logic pcw, input logic [DW-1:0] npc);
    @(negedge clk);
    mem_req = 1'b1; iord = ad_sel; mem_write = wr; ir_write = irw;
    from_alu = alu; mem_data = wdata; pc_write = pcw; new_pc = npc;
    @(posedge clk); #1;
    mem_req = 1'b0; mem_write = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
    busy_seen = mem_busy;
    lat = 0;
    while (!mem_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
`ifdef FMU_ADDR_CHECK_EN
    last_err = mem_err;
`endif
    @(posedge clk); #1;
    done_after = mem_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_pc !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", out_pc, RPC); end
    checks++; if (mdr !== 16'h0) begin failures++; $display("FAIL reset_mdr got=%h exp=0000", mdr); end
    checks++; if ({ir_regb, ir_rega, ir_regd, ir_ctrl} !== 19'h0) begin failures++; $display("FAIL reset_ir_fields got=%h exp=0", {ir_regb, ir_rega, ir_regd, ir_ctrl}); end
    checks++; if (ir_imm !== 16'h0) begin failures++; $display("FAIL reset_imm got=%h exp=0000", ir_imm); end
    checks++; if (mem_busy !== 1'b0 || mem_done !== 1'b0) begin failures++; $display("FAIL reset_status busy=%b done=%b exp=0,0", mem_busy, mem_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_decode();
    access(1'b1, 1'b1, 1'b0, 16'h0000, 16'h8E85, 1'b0, '0);
    model_op(1'b1, 1'b1, 1'b0, 16'h0000, 16'h8E85);
    checks++; if (lat !== WC + 1) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", lat, WC + 1); end
    checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done_after); end
    access(1'b0, 1'b0, 1'b1, 16'h0055, '0, 1'b0, '0);
    model_op(1'b0, 1'b0, 1'b1, 16'h0055, '0);
    checks++; if (lat !== WC + 1) begin failures++; $display("FAIL fetch_latency got=%0d exp=%0d", lat, WC + 1); end
    checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL fetch_busy got=%b exp=1", busy_seen); end
    checks++; if (ir_ctrl !== 7'h05) begin failures++; $display("FAIL fetch_control got=%h exp=05", ir_ctrl); end
    checks++; if (ir_rega !== 4'hD || ir_regd !== 4'hD) begin failures++; $display("FAIL fetch_rega_regd got=%h,%h exp=d,d", ir_rega, ir_regd); end
    checks++; if (ir_regb !== 4'h1) begin failures++; $display("FAIL fetch_regb got=%h exp=1", ir_regb); end
    checks++; if (ir_imm !== 16'hFF1D) begin failures++; $display("FAIL fetch_imm got=%h exp=ff1d", ir_imm); end
    checks++; if (mdr !== 16'h8E85) begin failures++; $display("FAIL fetch_mdr got=%h exp=8e85", mdr); end
  endtask

  task automatic test_data_rw();
    logic [DW-1:0] a, d;
    access(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234, 1'b0, '0);
    model_op(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    written_q.push_back(16);
    access(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, '0);
    model_op(1'b0, 1'b1, 1'b0, 16'h0010, '0);
    checks++; if (mdr !== 16'h1234) begin failures++; $display("FAIL data_read_mdr got=%h exp=1234", mdr); end
    checks++; if (ir_imm !== 16'hFF1D || ir_ctrl !== 7'h05) begin failures++; $display("FAIL data_read_ir_hold imm=%h ctrl=%h exp=ff1d,05", ir_imm, ir_ctrl); end
    for (int i = 0; i < 8; i++) begin
      a = DW'($urandom_range(1, DEPTH - 1));
      d = DW'($urandom);
      access(1'b1, 1'b1, 1'b0, a, d, 1'b0, '0);
      model_op(1'b1, 1'b1, 1'b0, a, d);
      written_q.push_back(int'(a));
      checks++; if (mdr !== m_mdr) begin failures++; $display("FAIL write_mdr_hold got=%h exp=%h", mdr, m_mdr); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a;
    for (int i = 0; i < 10; i++) begin
      a = DW'(written_q[$urandom_range(0, written_q.size() - 1)]);
      access(1'b0, 1'b1, 1'b0, a, '0, 1'b0, '0);
      model_op(1'b0, 1'b1, 1'b0, a, '0);
      checks++; if (lat !== WC + 1 || mdr !== m_mdr) begin failures++; $display("FAIL b2b_read addr=%h lat=%0d mdr=%h exp_lat=%0d exp_mdr=%h", a, lat, mdr, WC + 1, m_mdr); end
    end
  endtask

  task automatic test_pc_write();
    logic [DW-1:0] a;
    access(1'b0, 1'b0, 1'b1, '0, '0, 1'b1, 16'h00A5);
    model_op(1'b0, 1'b0, 1'b1, '0, '0);
    m_pc = 16'h00A5;
    checks++; if (mdr !== 16'h8E85 || ir_imm !== 16'hFF1D) begin failures++; $display("FAIL pc_same_edge_fetch mdr=%h imm=%h exp=8e85,ff1d", mdr, ir_imm); end
    checks++; if (out_pc !== 16'h00A5) begin failures++; $display("FAIL pc_same_edge_pc got=%h exp=00a5", out_pc); end
    for (int i = 0; i < 4; i++) begin
      a = DW'(written_q[$urandom_range(0, written_q.size() - 1)]);
      @(negedge clk); pc_write = 1'b1; new_pc = a;
      @(posedge clk); #1; pc_write = 1'b0;
      m_pc = a;
      checks++; if (out_pc !== m_pc) begin failures++; $display("FAIL pc_load got=%h exp=%h", out_pc, m_pc); end
      access(1'b0, 1'b0, 1'b1, 16'hFFFF, '0, 1'b0, '0);
      model_op(1'b0, 1'b0, 1'b1, 16'hFFFF, '0);
      checks++;
      if (ir_ctrl !== 7'(m_ir) || ir_rega !== 4'(m_ir >> 7) || ir_regb !== 4'(m_ir >> 11) ||
          ir_regd !== 4'(m_ir >> 7) || ir_imm !== DW'($signed(m_ir) >>> 7)) begin
        failures++;
        $display("FAIL pc_fetch_decode pc=%h ctrl=%h a=%h b=%h imm=%h exp_ir=%h", m_pc, ir_ctrl, ir_rega, ir_regb, ir_imm, m_ir);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int dones, first_done;
    logic [DW-1:0] a;
    a = DW'(written_q[written_q.size() - 1]);
    @(negedge clk);
    mem_req = 1'b1; iord = 1'b1; mem_write = 1'b0; ir_write = 1'b0; from_alu = a;
    @(posedge clk); #1;
    model_op(1'b0, 1'b1, 1'b0, a, '0);
    from_alu = 16'h0000; mem_write = 1'b1; mem_data = 16'hBEEF;
    dones = 0; first_done = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == WC + 2) begin mem_req = 1'b0; mem_write = 1'b0; end
      if (mem_done) begin
        dones++;
        if (first_done == 0) first_done = i;
      end
    end
    checks++; if (dones !== 1) begin failures++; $display("FAIL busy_ignore_done_count got=%0d exp=1", dones); end
    checks++; if (first_done !== WC + 1) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=%0d", first_done, WC + 1); end
    checks++; if (mdr !== m_mdr) begin failures++; $display("FAIL busy_ignore_mdr got=%h exp=%h", mdr, m_mdr); end
    access(1'b0, 1'b1, 1'b0, 16'h0000, '0, 1'b0, '0);
    model_op(1'b0, 1'b1, 1'b0, 16'h0000, '0);
    checks++; if (mdr !== m_mdr) begin failures++; $display("FAIL busy_ignore_no_write got=%h exp=%h", mdr, m_mdr); end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] d;
    d = ~m_mem[16];
    @(negedge clk);
    mem_req = 1'b1; iord = 1'b1; mem_write = 1'b1; from_alu = 16'h0010; mem_data = d;
    @(posedge clk); #1;
    mem_req = 1'b0; mem_write = 1'b0;
    checks++; if (mem_busy !== 1'b1) begin failures++; $display("FAIL abort_in_wait busy=%b exp=1", mem_busy); end
    rst_n = 1'b0;
    #2;
    m_pc = RPC; m_mdr = '0; m_ir = '0;
    checks++; if (mdr !== 16'h0 || ir_imm !== 16'h0 || ir_ctrl !== 7'h0) begin failures++; $display("FAIL abort_regs mdr=%h imm=%h ctrl=%h exp=0", mdr, ir_imm, ir_ctrl); end
    checks++; if (out_pc !== RPC || mem_busy !== 1'b0) begin failures++; $display("FAIL abort_pc_busy pc=%h busy=%b exp=%h,0", out_pc, mem_busy, RPC); end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    access(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, '0);
    model_op(1'b0, 1'b1, 1'b0, 16'h0010, '0);
    checks++; if (mdr !== m_mdr) begin failures++; $display("FAIL abort_word_kept got=%h exp=%h", mdr, m_mdr); end
  endtask

  task automatic test_addr_range();
    access(1'b0, 1'b1, 1'b0, 16'h0400, '0, 1'b0, '0);
    model_op(1'b0, 1'b1, 1'b0, 16'h0400, '0);
    checks++; if (lat !== WC + 1) begin failures++; $display("FAIL range_latency got=%0d exp=%0d", lat, WC + 1); end
`ifdef FMU_ADDR_CHECK_EN
    checks++; if (last_err !== 1'b1) begin failures++; $display("FAIL range_err got=%b exp=1", last_err); end
    checks++; if (mdr !== 16'h0) begin failures++; $display("FAIL range_mdr got=%h exp=0000", mdr); end
    access(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, '0);
    model_op(1'b0, 1'b1, 1'b0, 16'h0010, '0);
    checks++; if (last_err !== 1'b0) begin failures++; $display("FAIL inrange_err got=%b exp=0", last_err); end
`else
    checks++; if (mdr !== m_mem[0] || mdr !== 16'h8E85) begin failures++; $display("FAIL range_wrap_mdr got=%h exp=8e85", mdr); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch_decode();
    test_data_rw();
    test_back_to_back();
    test_pc_write();
    test_busy_ignore();
    test_reset_abort();
    test_addr_range();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
